// File: rtl/pc_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32_fetch_pkg
// Shared definitions for the RV32I fetch-stage next-PC controller:
//   - XLEN            : address/PC width
//   - PCSEL_*         : encodings of the PC mux select (pc_sel)
//   - fsm_state_e     : redirect controller states
//   - pc_plus4()      : sequential successor, wraps modulo 2^XLEN
// ---------------------------------------------------------------------------
package rv32_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] PCSEL_SEQ   = 2'd0;  // PC + 4
  localparam logic [1:0] PCSEL_BTB   = 2'd1;  // BTB predicted target
  localparam logic [1:0] PCSEL_REDIR = 2'd2;  // redirect_pc
  localparam logic [1:0] PCSEL_HOLD  = 2'd3;  // keep current PC

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // normal fetch
    ST_WAIT = 2'd1,  // imem busy, nothing pending
    ST_PEND = 2'd2   // redirect latched, waiting for imem
  } fsm_state_e;

  // Sequential successor; the add wraps naturally at the top of the space.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + {{(XLEN-3){1'b0}}, 3'b100};
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl_if
// Bundle of all redirect-source inputs and PC/pipeline control outputs of
// pc_redirect_ctrl.
//   slave  : controller side (sources in, controls out)
//   master : environment side (sources out, controls in)
// ---------------------------------------------------------------------------
interface pc_redirect_ctrl_if #(
  parameter int XLEN = rv32_fetch_pkg::XLEN
) ();

  // Redirect sources and fetch status
  logic            imem_ready;
  logic            load_use_stall;
  logic            ex_resolved;
  logic            ex_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            id_jump;
  logic [XLEN-1:0] id_jump_target;
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  // PC and pipeline controls
  logic            pc_write;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] redirect_pc;
  logic            ifid_write;
  logic            ifid_flush;
  logic            idex_flush;
  logic            btb_upd_en;
  logic [XLEN-1:0] btb_upd_pc;
  logic [XLEN-1:0] btb_upd_target;
  logic            btb_upd_taken;
  logic            busy;

  modport slave (
    input  imem_ready, load_use_stall, ex_resolved, ex_taken, ex_pc, ex_target,
           ex_pred_taken, ex_pred_target, id_jump, id_jump_target, btb_hit,
           btb_target,
    output pc_write, pc_sel, redirect_pc, ifid_write, ifid_flush, idex_flush,
           btb_upd_en, btb_upd_pc, btb_upd_target, btb_upd_taken, busy
  );

  modport master (
    output imem_ready, load_use_stall, ex_resolved, ex_taken, ex_pc, ex_target,
           ex_pred_taken, ex_pred_target, id_jump, id_jump_target, btb_hit,
           btb_target,
    input  pc_write, pc_sel, redirect_pc, ifid_write, ifid_flush, idex_flush,
           btb_upd_en, btb_upd_pc, btb_upd_target, btb_upd_taken, busy
  );

endinterface

// File: rtl/pc_redirect_ctrl_mispredict_detect.sv
// ---------------------------------------------------------------------------
// mispredict_detect
// Combinational branch-resolution check for the branch in EX.
//   inputs : ex_resolved_i, ex_taken_i, ex_pc_i, ex_target_i,
//            ex_pred_taken_i, ex_pred_target_i
//   outputs: mispredict_o  - direction wrong, or taken with wrong target
//            correct_pc_o  - where fetch should have gone
// ---------------------------------------------------------------------------
module mispredict_detect #(
  parameter int XLEN = 32
) (
  input  logic            ex_resolved_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] correct_pc_o
);

  logic [XLEN-1:0] fallthru_s;

  // Not-taken path wraps modulo 2^XLEN.
  assign fallthru_s   = ex_pc_i + {{(XLEN-3){1'b0}}, 3'b100};
  assign correct_pc_o = ex_taken_i ? ex_target_i : fallthru_s;

  // A predicted-taken branch that goes elsewhere is also a miss.
  assign mispredict_o = ex_resolved_i &
                        ((ex_taken_i != ex_pred_taken_i) |
                         (ex_taken_i & (ex_target_i != ex_pred_target_i)));

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
// Next-PC controller for the RV32I fetch stage. Arbitrates EX mispredict,
// ID jump, load-use stall and BTB hit against instruction-memory wait, and
// latches a redirect seen while fetch is blocked so it is replayed later.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus    - pc_redirect_ctrl_if.slave (sources in, PC/pipeline controls out)
//   [PC_REDIRECT_PERF_EN] mispredict_cnt_o, jump_cnt_o, stall_cnt_o
//            - 32-bit saturating event counters
// Control outputs are combinational from state and inputs; the BTB update
// strobe and its payload are registered one cycle after resolution.
// Optional feature macro: PC_REDIRECT_PERF_EN
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter int              XLEN     = rv32_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef PC_REDIRECT_PERF_EN
  output logic [31:0]         mispredict_cnt_o,
  output logic [31:0]         jump_cnt_o,
  output logic [31:0]         stall_cnt_o,
`endif
  pc_redirect_ctrl_if.slave   bus
);

  import rv32_fetch_pkg::*;

  fsm_state_e      state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            btb_en_q;
  logic [XLEN-1:0] btb_pc_q, btb_tgt_q;
  logic            btb_tk_q;

  logic            mispred_s;
  logic [XLEN-1:0] correct_pc_s;
  logic            redir_s;
  logic [XLEN-1:0] redir_tgt_s;

  logic            pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s;
  logic [1:0]      pc_sel_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            ev_mis_s, ev_jump_s, ev_stall_s;

  mispredict_detect #(.XLEN(XLEN)) u_mispredict_detect (
    .ex_resolved_i   (bus.ex_resolved),
    .ex_taken_i      (bus.ex_taken),
    .ex_pc_i         (bus.ex_pc),
    .ex_target_i     (bus.ex_target),
    .ex_pred_taken_i (bus.ex_pred_taken),
    .ex_pred_target_i(bus.ex_pred_target),
    .mispredict_o    (mispred_s),
    .correct_pc_o    (correct_pc_s)
  );

  // EX outranks ID when both redirect in the same cycle.
  assign redir_s     = mispred_s | bus.id_jump;
  assign redir_tgt_s = mispred_s ? correct_pc_s : bus.id_jump_target;

  // Next-state and control decode
  always_comb begin
    pc_write_s    = 1'b0;
    pc_sel_s      = PCSEL_HOLD;
    redirect_pc_s = pend_pc_q;
    ifid_write_s  = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    state_d       = state_q;
    pend_pc_d     = pend_pc_q;
    ev_mis_s      = 1'b0;
    ev_jump_s     = 1'b0;
    ev_stall_s    = 1'b0;
    if (rst_i) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_WAIT: begin
          // WAIT only resumes directly when no redirect shows up.
          if (bus.imem_ready && ((state_q == ST_RUN) || !redir_s)) begin
            state_d      = ST_RUN;
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            if (mispred_s) begin
              pc_sel_s      = PCSEL_REDIR;
              redirect_pc_s = correct_pc_s;
              ifid_flush_s  = 1'b1;
              idex_flush_s  = 1'b1;
              ev_mis_s      = 1'b1;
            end else if (bus.id_jump) begin
              pc_sel_s      = PCSEL_REDIR;
              redirect_pc_s = bus.id_jump_target;
              ifid_flush_s  = 1'b1;
              ev_jump_s     = 1'b1;
            end else if (bus.load_use_stall) begin
              pc_sel_s     = PCSEL_HOLD;
              pc_write_s   = 1'b0;
              ifid_write_s = 1'b0;
              ev_stall_s   = 1'b1;
            end else if (bus.btb_hit && (state_q == ST_RUN)) begin
              pc_sel_s = PCSEL_BTB;
            end else begin
              pc_sel_s = PCSEL_SEQ;
            end
          end else if (redir_s) begin
            // Fetch blocked: squash now, replay the target later.
            ifid_flush_s = 1'b1;
            idex_flush_s = mispred_s;
            pend_pc_d    = redir_tgt_s;
            state_d      = ST_PEND;
            ev_mis_s     = mispred_s;
            ev_jump_s    = ~mispred_s;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_PEND: begin
          // ID jumps here sit on the squashed path and are ignored.
          ev_mis_s = mispred_s;
          if (bus.imem_ready) begin
            pc_sel_s      = PCSEL_REDIR;
            redirect_pc_s = mispred_s ? correct_pc_s : pend_pc_q;
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = mispred_s;
            state_d       = ST_RUN;
          end else if (mispred_s) begin
            pend_pc_d    = correct_pc_s;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else begin
            pend_pc_d = pend_pc_q;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // FSM state, pending target and one-cycle BTB update strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      pend_pc_q <= RESET_PC;
      btb_en_q  <= 1'b0;
      btb_pc_q  <= {XLEN{1'b0}};
      btb_tgt_q <= {XLEN{1'b0}};
      btb_tk_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      btb_en_q  <= bus.ex_resolved;
      if (bus.ex_resolved) begin
        btb_pc_q  <= bus.ex_pc;
        btb_tgt_q <= bus.ex_target;
        btb_tk_q  <= bus.ex_taken;
      end
    end
  end

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] mis_cnt_q, jmp_cnt_q, stl_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mis_cnt_q <= 32'd0;
      jmp_cnt_q <= 32'd0;
      stl_cnt_q <= 32'd0;
    end else begin
      if (ev_mis_s && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 32'd1;
      if (ev_jump_s && (jmp_cnt_q != 32'hFFFF_FFFF)) jmp_cnt_q <= jmp_cnt_q + 32'd1;
      if (ev_stall_s && (stl_cnt_q != 32'hFFFF_FFFF)) stl_cnt_q <= stl_cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt_o = mis_cnt_q;
  assign jump_cnt_o       = jmp_cnt_q;
  assign stall_cnt_o      = stl_cnt_q;
`else
  logic unused_ev_s;
  assign unused_ev_s = ev_mis_s ^ ev_jump_s ^ ev_stall_s;
`endif

  assign bus.pc_write       = pc_write_s;
  assign bus.pc_sel         = pc_sel_s;
  assign bus.redirect_pc    = redirect_pc_s;
  assign bus.ifid_write     = ifid_write_s;
  assign bus.ifid_flush     = ifid_flush_s;
  assign bus.idex_flush     = idex_flush_s;
  assign bus.btb_upd_en     = btb_en_q;
  assign bus.btb_upd_pc     = btb_pc_q;
  assign bus.btb_upd_target = btb_tgt_q;
  assign bus.btb_upd_taken  = btb_tk_q;
  assign bus.busy           = (state_q != ST_RUN);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
// Table-driven bench for pc_redirect_ctrl: each record holds one cycle of
// inputs and the expected same-cycle controls; expected BTB updates are
// queued one cycle ahead and compared when the registered strobe appears.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;
  import rv32_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_ctrl_if #(.XLEN(32)) bus ();

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] mis_cnt, jmp_cnt, stl_cnt;
`endif

  pc_redirect_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
`ifdef PC_REDIRECT_PERF_EN
    .mispredict_cnt_o(mis_cnt),
    .jump_cnt_o      (jmp_cnt),
    .stall_cnt_o     (stl_cnt),
`endif
    .bus             (bus)
  );

  typedef struct {
    logic        rdy, stall, res, tk, ptk;
    logic [31:0] epc, etgt, ptgt;
    logic        jmp;
    logic [31:0] jtgt;
    logic        btb;
    logic [1:0]  e_sel;
    logic [31:0] e_rpc;
    logic        e_pcw, e_ifw, e_iff, e_idf, e_busy;
  } vec_t;

  typedef struct {
    logic        en;
    logic [31:0] pc, tgt;
    logic        tk;
  } btb_exp_t;

  vec_t     sb_q[$];
  btb_exp_t btb_q[$];
  int       errors = 0;
  int       checks = 0;

  function automatic vec_t mk(
    input logic rdy, stall, res, tk, ptk,
    input logic [31:0] epc, etgt, ptgt,
    input logic jmp, input logic [31:0] jtgt, input logic btb,
    input logic [1:0] e_sel, input logic [31:0] e_rpc,
    input logic e_pcw, e_ifw, e_iff, e_idf, e_busy);
    vec_t v;
    v.rdy = rdy; v.stall = stall; v.res = res; v.tk = tk; v.ptk = ptk;
    v.epc = epc; v.etgt = etgt; v.ptgt = ptgt;
    v.jmp = jmp; v.jtgt = jtgt; v.btb = btb;
    v.e_sel = e_sel; v.e_rpc = e_rpc;
    v.e_pcw = e_pcw; v.e_ifw = e_ifw; v.e_iff = e_iff; v.e_idf = e_idf;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    vec_t     e;
    btb_exp_t b;
    btb_exp_t nb;
    @(posedge clk);
    #1;
    bus.imem_ready     = v.rdy;
    bus.load_use_stall = v.stall;
    bus.ex_resolved    = v.res;
    bus.ex_taken       = v.tk;
    bus.ex_pred_taken  = v.ptk;
    bus.ex_pc          = v.epc;
    bus.ex_target      = v.etgt;
    bus.ex_pred_target = v.ptgt;
    bus.id_jump        = v.jmp;
    bus.id_jump_target = v.jtgt;
    bus.btb_hit        = v.btb;
    bus.btb_target     = 32'h0000_0080;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({tag, ".pc_write"},   {31'd0, bus.pc_write},   {31'd0, e.e_pcw});
    chk({tag, ".pc_sel"},     {30'd0, bus.pc_sel},     {30'd0, e.e_sel});
    if (e.e_sel == PCSEL_REDIR)
      chk({tag, ".redirect_pc"}, bus.redirect_pc, e.e_rpc);
    chk({tag, ".ifid_write"}, {31'd0, bus.ifid_write}, {31'd0, e.e_ifw});
    chk({tag, ".ifid_flush"}, {31'd0, bus.ifid_flush}, {31'd0, e.e_iff});
    chk({tag, ".idex_flush"}, {31'd0, bus.idex_flush}, {31'd0, e.e_idf});
    chk({tag, ".busy"},       {31'd0, bus.busy},       {31'd0, e.e_busy});
    b = btb_q.pop_front();
    chk({tag, ".btb_upd_en"}, {31'd0, bus.btb_upd_en}, {31'd0, b.en});
    if (b.en) begin
      chk({tag, ".btb_upd_pc"},     bus.btb_upd_pc,     b.pc);
      chk({tag, ".btb_upd_target"}, bus.btb_upd_target, b.tgt);
      chk({tag, ".btb_upd_taken"},  {31'd0, bus.btb_upd_taken}, {31'd0, b.tk});
    end
    nb.en = v.res; nb.pc = v.epc; nb.tgt = v.etgt; nb.tk = v.tk;
    btb_q.push_back(nb);
  endtask

  vec_t tbl[13];
  vec_t seq_v[20];

  initial begin
    //          rdy stl res tk ptk epc           etgt          ptgt          jmp jtgt          btb sel          rpc           pcw ifw iff idf busy
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        0, PCSEL_SEQ,   32'h0,        1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1, PCSEL_BTB,   32'h0,        1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 0, 32'h50,       32'h100,      32'h0,        0, 32'h0,        0, PCSEL_REDIR, 32'h100,      1, 1, 1, 1, 0);
    tbl[3]  = mk(1, 0, 1, 0, 1, 32'hFFFFFFFC, 32'h10,       32'h10,       0, 32'h0,        0, PCSEL_REDIR, 32'h0,        1, 1, 1, 1, 0);
    tbl[4]  = mk(1, 0, 1, 1, 0, 32'h20,       32'h200,      32'h0,        1, 32'h300,      0, PCSEL_REDIR, 32'h200,      1, 1, 1, 1, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h300,      0, PCSEL_REDIR, 32'h300,      1, 1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 1, 1, 1, 32'h30,       32'h400,      32'h400,      0, 32'h0,        0, PCSEL_SEQ,   32'h0,        1, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 1, 1, 32'h60,       32'h500,      32'h480,      0, 32'h0,        0, PCSEL_REDIR, 32'h500,      1, 1, 1, 1, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 32'h70,       32'h700,      32'h0,        0, 32'h0,        0, PCSEL_SEQ,   32'h0,        1, 1, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1, PCSEL_HOLD,  32'h0,        0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1, PCSEL_BTB,   32'h0,        1, 1, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h900,      1, PCSEL_REDIR, 32'h900,      1, 1, 1, 0, 0);
    tbl[12] = mk(1, 1, 1, 1, 1, 32'h80,       32'h84,       32'h88,       0, 32'h0,        1, PCSEL_REDIR, 32'h84,       1, 1, 1, 1, 0);

    // Blocked fetch with ID jump, replay on ready
    seq_v[0]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 1, 32'h40,  0, PCSEL_HOLD,  32'h0,   0, 0, 1, 0, 0);
    seq_v[1]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_HOLD,  32'h0,   0, 0, 0, 0, 1);
    seq_v[2]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_HOLD,  32'h0,   0, 0, 0, 0, 1);
    seq_v[3]  = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_REDIR, 32'h40,  1, 1, 1, 0, 1);
    seq_v[4]  = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_SEQ,   32'h0,   1, 1, 0, 0, 0);
    // WAIT: BTB hit ignored, resume sequentially
    seq_v[5]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_HOLD,  32'h0,   0, 0, 0, 0, 0);
    seq_v[6]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   1, PCSEL_HOLD,  32'h0,   0, 0, 0, 0, 1);
    seq_v[7]  = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   1, PCSEL_SEQ,   32'h0,   1, 1, 0, 0, 1);
    seq_v[8]  = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_SEQ,   32'h0,   1, 1, 0, 0, 0);
    // PEND overwritten by EX mispredict; later ID jump ignored
    seq_v[9]  = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 1, 32'h40,  0, PCSEL_HOLD,  32'h0,   0, 0, 1, 0, 0);
    seq_v[10] = mk(0, 0, 1, 1, 0, 32'h90, 32'h900, 32'h0, 0, 32'h0,   0, PCSEL_HOLD,  32'h0,   0, 0, 1, 1, 1);
    seq_v[11] = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 1, 32'h777, 0, PCSEL_REDIR, 32'h900, 1, 1, 1, 0, 1);
    seq_v[12] = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_SEQ,   32'h0,   1, 1, 0, 0, 0);
    // WAIT, then not-taken mispredict latched (ex_pc+4)
    seq_v[13] = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_HOLD,  32'h0,   0, 0, 0, 0, 0);
    seq_v[14] = mk(0, 0, 1, 0, 1, 32'hA0, 32'hBB0, 32'hBB0, 0, 32'h0, 0, PCSEL_HOLD,  32'h0,   0, 0, 1, 1, 1);
    seq_v[15] = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_REDIR, 32'hA4,  1, 1, 1, 0, 1);
    seq_v[16] = mk(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,   0, PCSEL_SEQ,   32'h0,   1, 1, 0, 0, 0);

    bus.imem_ready = 1'b1; bus.load_use_stall = 1'b0; bus.ex_resolved = 1'b0;
    bus.ex_taken = 1'b0; bus.ex_pred_taken = 1'b0; bus.ex_pc = 32'h0;
    bus.ex_target = 32'h0; bus.ex_pred_target = 32'h0; bus.id_jump = 1'b0;
    bus.id_jump_target = 32'h0; bus.btb_hit = 1'b0; bus.btb_target = 32'h0;

    // Reset held for two cycles
    @(negedge clk);
    chk("rst.pc_write",   {31'd0, bus.pc_write},   32'd0);
    chk("rst.ifid_flush", {31'd0, bus.ifid_flush}, 32'd1);
    chk("rst.idex_flush", {31'd0, bus.idex_flush}, 32'd1);
    @(negedge clk);
    chk("rst.busy",       {31'd0, bus.busy},       32'd0);
    chk("rst.btb_upd_en", {31'd0, bus.btb_upd_en}, 32'd0);
    rst = 1'b0;
    begin
      btb_exp_t b0;
      b0.en = 1'b0; b0.pc = 32'h0; b0.tgt = 32'h0; b0.tk = 1'b0;
      btb_q.push_back(b0);
    end

    for (int i = 0; i < 13; i++) apply($sformatf("tbl%0d", i), tbl[i]);
    for (int i = 0; i < 17; i++) apply($sformatf("seq%0d", i), seq_v[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
